// File: rtl/lc3_mem_access_seq.sv
// LC3 MemAccess-stage sequencer: turns one load/store request into data-memory strobes.
// Optional write protection of the upper address window is enabled by LC3_MEM_ACCESS_PROT_EN.
module lc3_mem_access_seq #(
    parameter int RD_LATENCY = 1,
    parameter int AW         = 16
`ifdef LC3_MEM_ACCESS_PROT_EN
    ,
    parameter logic [AW-1:0] PROT_BASE = 16'hFE00
`endif
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_wdata,
    output logic [AW-1:0] Data_addr,
    output logic [AW-1:0] Data_din,
    output logic          Data_rd,
    output logic          Data_en,
    input  logic [AW-1:0] Data_dout,
    output logic          resp_valid,
    output logic [AW-1:0] resp_data,
`ifdef LC3_MEM_ACCESS_PROT_EN
    output logic          resp_err,
`endif
    output logic          busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE1 = 3'd1,
        ST_WAIT1  = 3'd2,
        ST_ISSUE2 = 3'd3,
        ST_WAIT2  = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    localparam logic [1:0] OP_LOAD      = 2'b00;
    localparam logic [1:0] OP_LOAD_IND  = 2'b01;
    localparam logic [1:0] OP_STORE     = 2'b10;
    localparam logic [1:0] OP_STORE_IND = 2'b11;
    localparam logic [2:0] LAT_LAST     = 3'(RD_LATENCY - 1);

    state_t        state_r;
    logic [1:0]    op_r;
    logic [AW-1:0] wdata_r;
    logic [2:0]    cnt_r;
    logic          wr_blk1_s;
    logic          wr_blk2_s;
`ifdef LC3_MEM_ACCESS_PROT_EN
    logic          err_r;
`endif

    // Write-protection decode for the direct store address and the fetched STI pointer.
    always_comb begin
`ifdef LC3_MEM_ACCESS_PROT_EN
        wr_blk1_s = (req_addr >= PROT_BASE);
        wr_blk2_s = (Data_dout >= PROT_BASE);
`else
        wr_blk1_s = 1'b0;
        wr_blk2_s = 1'b0;
`endif
    end

    // Sequencer FSM; memory strobes are registered so they appear in the cycle named by the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            op_r       <= OP_LOAD;
            wdata_r    <= '0;
            cnt_r      <= 3'd0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            Data_addr  <= '0;
            Data_din   <= '0;
            Data_rd    <= 1'b1;
            Data_en    <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
`ifdef LC3_MEM_ACCESS_PROT_EN
            err_r      <= 1'b0;
            resp_err   <= 1'b0;
`endif
        end else begin
            Data_en    <= 1'b0;
            Data_rd    <= 1'b1;
            resp_valid <= 1'b0;
`ifdef LC3_MEM_ACCESS_PROT_EN
            resp_err   <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        state_r   <= ST_ISSUE1;
                        op_r      <= req_op;
                        wdata_r   <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (req_op == OP_STORE) begin
                            if (!wr_blk1_s) begin
                                Data_en   <= 1'b1;
                                Data_rd   <= 1'b0;
                                Data_addr <= req_addr;
                                Data_din  <= req_wdata;
                            end
`ifdef LC3_MEM_ACCESS_PROT_EN
                            err_r <= wr_blk1_s;
`endif
                        end else begin
                            Data_en   <= 1'b1;
                            Data_addr <= req_addr;
`ifdef LC3_MEM_ACCESS_PROT_EN
                            err_r <= 1'b0;
`endif
                        end
                    end
                end
                ST_ISSUE1: begin
                    if (op_r == OP_STORE) begin
                        state_r    <= ST_RESP;
                        resp_valid <= 1'b1;
`ifdef LC3_MEM_ACCESS_PROT_EN
                        resp_err   <= err_r;
`endif
                    end else begin
                        state_r <= ST_WAIT1;
                        cnt_r   <= 3'd0;
                    end
                end
                ST_WAIT1: begin
                    if (cnt_r == LAT_LAST) begin
                        if (op_r == OP_LOAD) begin
                            state_r    <= ST_RESP;
                            resp_data  <= Data_dout;
                            resp_valid <= 1'b1;
                        end else if (op_r == OP_STORE_IND) begin
                            // The fetched pointer goes straight onto the address bus for the second access.
                            state_r <= ST_ISSUE2;
                            if (!wr_blk2_s) begin
                                Data_en   <= 1'b1;
                                Data_rd   <= 1'b0;
                                Data_addr <= Data_dout;
                                Data_din  <= wdata_r;
                            end
`ifdef LC3_MEM_ACCESS_PROT_EN
                            err_r <= wr_blk2_s;
`endif
                        end else begin
                            state_r   <= ST_ISSUE2;
                            Data_en   <= 1'b1;
                            Data_addr <= Data_dout;
                        end
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                ST_ISSUE2: begin
                    if (op_r == OP_LOAD_IND) begin
                        state_r <= ST_WAIT2;
                        cnt_r   <= 3'd0;
                    end else begin
                        state_r    <= ST_RESP;
                        resp_valid <= 1'b1;
`ifdef LC3_MEM_ACCESS_PROT_EN
                        resp_err   <= err_r;
`endif
                    end
                end
                ST_WAIT2: begin
                    if (cnt_r == LAT_LAST) begin
                        state_r    <= ST_RESP;
                        resp_data  <= Data_dout;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                ST_RESP: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_access_seq.sv
// Directed bench for lc3_mem_access_seq: one instance at RD_LATENCY=1 and one at RD_LATENCY=3,
// each with its own fixed-latency memory model and write log.
module tb_lc3_mem_access_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_op;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_valid1;
    logic        req_valid3;

    logic        req_ready1, busy1, Data_rd1, Data_en1, resp_valid1;
    logic [15:0] Data_addr1, Data_din1, resp_data1;
    logic [15:0] Data_dout1 = 16'h0000;
    logic        req_ready3, busy3, Data_rd3, Data_en3, resp_valid3;
    logic [15:0] Data_addr3, Data_din3, resp_data3;
    logic [15:0] Data_dout3 = 16'h0000;
`ifdef LC3_MEM_ACCESS_PROT_EN
    logic        resp_err1, resp_err3;
`endif

    logic [15:0] mem [0:65535];
    logic [15:0] pipe3_a = 16'h0000;
    logic [15:0] pipe3_b = 16'h0000;
    int          wr_cnt1 = 0;
    int          wr_cnt3 = 0;
    logic [15:0] wr_addr1 = 16'h0000;
    logic [15:0] wr_data1 = 16'h0000;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    lc3_mem_access_seq #(.RD_LATENCY(1), .AW(16)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .Data_addr(Data_addr1), .Data_din(Data_din1), .Data_rd(Data_rd1),
        .Data_en(Data_en1), .Data_dout(Data_dout1),
        .resp_valid(resp_valid1), .resp_data(resp_data1),
`ifdef LC3_MEM_ACCESS_PROT_EN
        .resp_err(resp_err1),
`endif
        .busy(busy1)
    );

    lc3_mem_access_seq #(.RD_LATENCY(3), .AW(16)) dut3 (
        .clock(clock), .reset(reset),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .Data_addr(Data_addr3), .Data_din(Data_din3), .Data_rd(Data_rd3),
        .Data_en(Data_en3), .Data_dout(Data_dout3),
        .resp_valid(resp_valid3), .resp_data(resp_data3),
`ifdef LC3_MEM_ACCESS_PROT_EN
        .resp_err(resp_err3),
`endif
        .busy(busy3)
    );

    // One-cycle read latency memory plus write log for dut1.
    always @(posedge clock) begin
        Data_dout1 <= (Data_en1 && Data_rd1) ? mem[Data_addr1] : 16'h0000;
        if (Data_en1 && !Data_rd1) begin
            wr_cnt1  <= wr_cnt1 + 1;
            wr_addr1 <= Data_addr1;
            wr_data1 <= Data_din1;
        end
    end

    // Three-cycle read latency memory plus write counter for dut3.
    always @(posedge clock) begin
        pipe3_a    <= (Data_en3 && Data_rd3) ? mem[Data_addr3] : 16'h0000;
        pipe3_b    <= pipe3_a;
        Data_dout3 <= pipe3_b;
        if (Data_en3 && !Data_rd3) begin
            wr_cnt3 <= wr_cnt3 + 1;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid1 = 1'b0;
        req_valid3 = 1'b0;
        req_op     = 2'b00;
        req_addr   = 16'h0000;
        req_wdata  = 16'h0000;
        mem[16'h3010] = 16'hBEEF;
        mem[16'h3020] = 16'h4000;
        mem[16'h3000] = 16'hFFFF;
        mem[16'hFFFF] = 16'h00A5;
        mem[16'h3040] = 16'h5000;

        // Reset held two cycles, then idle outputs.
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_ready1", 16'(req_ready1), 16'h0001);
        chk("rst_busy1", 16'(busy1), 16'h0000);
        chk("rst_en1", 16'(Data_en1), 16'h0000);
        chk("rst_rd1", 16'(Data_rd1), 16'h0001);
        chk("rst_rv1", 16'(resp_valid1), 16'h0000);
        chk("rst_rdata1", resp_data1, 16'h0000);
        chk("rst_addr1", Data_addr1, 16'h0000);
        chk("rst_ready3", 16'(req_ready3), 16'h0001);
        chk("rst_en3", 16'(Data_en3), 16'h0000);
        chk("rst_rdata3", resp_data3, 16'h0000);

        // LOAD 0x3010 on the latency-1 instance: read in cycle 1, response in cycle 3.
        req_op = 2'b00; req_addr = 16'h3010; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("ld_c1_en", 16'(Data_en1), 16'h0001);
        chk("ld_c1_rd", 16'(Data_rd1), 16'h0001);
        chk("ld_c1_addr", Data_addr1, 16'h3010);
        chk("ld_c1_ready", 16'(req_ready1), 16'h0000);
        chk("ld_c1_busy", 16'(busy1), 16'h0001);
        tick();
        chk("ld_c2_en", 16'(Data_en1), 16'h0000);
        chk("ld_c2_rv", 16'(resp_valid1), 16'h0000);
        tick();
        chk("ld_c3_rv", 16'(resp_valid1), 16'h0001);
        chk("ld_c3_data", resp_data1, 16'hBEEF);
        tick();
        chk("ld_c4_rv", 16'(resp_valid1), 16'h0000);
        chk("ld_c4_ready", 16'(req_ready1), 16'h0001);

        // STORE_IND through pointer at 0x3020 (=0x4000) writing 0x1234.
        req_op = 2'b11; req_addr = 16'h3020; req_wdata = 16'h1234; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("sti_c1_en", 16'(Data_en1), 16'h0001);
        chk("sti_c1_rd", 16'(Data_rd1), 16'h0001);
        chk("sti_c1_addr", Data_addr1, 16'h3020);
        tick();
        chk("sti_c2_en", 16'(Data_en1), 16'h0000);
        tick();
        chk("sti_c3_en", 16'(Data_en1), 16'h0001);
        chk("sti_c3_rd", 16'(Data_rd1), 16'h0000);
        chk("sti_c3_addr", Data_addr1, 16'h4000);
        chk("sti_c3_din", Data_din1, 16'h1234);
        tick();
        chk("sti_c4_rv", 16'(resp_valid1), 16'h0001);
        chk("sti_c4_hold", resp_data1, 16'hBEEF);
        chk("sti_wr_cnt", 16'(wr_cnt1), 16'h0001);
        chk("sti_wr_addr", wr_addr1, 16'h4000);
        chk("sti_wr_data", wr_data1, 16'h1234);
        tick();
        chk("sti_c5_ready", 16'(req_ready1), 16'h0001);
        chk("sti_c5_rv", 16'(resp_valid1), 16'h0000);

        // Plain STORE to address 0x0000: write in cycle 1, response in cycle 2.
        req_op = 2'b10; req_addr = 16'h0000; req_wdata = 16'h5A5A; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("st_c1_en", 16'(Data_en1), 16'h0001);
        chk("st_c1_rd", 16'(Data_rd1), 16'h0000);
        chk("st_c1_addr", Data_addr1, 16'h0000);
        chk("st_c1_din", Data_din1, 16'h5A5A);
        tick();
        chk("st_c2_rv", 16'(resp_valid1), 16'h0001);
        chk("st_c2_rd", 16'(Data_rd1), 16'h0001);
        chk("st_c2_hold", resp_data1, 16'hBEEF);
        chk("st_wr_cnt", 16'(wr_cnt1), 16'h0002);
        chk("st_wr_data", wr_data1, 16'h5A5A);
        tick();
        chk("st_c3_ready", 16'(req_ready1), 16'h0001);

        // LOAD_IND on the latency-3 instance with req_valid held throughout busy.
        req_op = 2'b01; req_addr = 16'h3000; req_valid3 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("ldi_c%0d_en", c), 16'(Data_en3), (c == 1 || c == 5) ? 16'h0001 : 16'h0000);
            chk($sformatf("ldi_c%0d_rv", c), 16'(resp_valid3), (c == 9) ? 16'h0001 : 16'h0000);
            chk($sformatf("ldi_c%0d_ready", c), 16'(req_ready3), 16'h0000);
            if (c == 1) chk("ldi_c1_addr", Data_addr3, 16'h3000);
            if (c == 5) chk("ldi_c5_addr", Data_addr3, 16'hFFFF);
            if (c == 5) chk("ldi_c5_rd", 16'(Data_rd3), 16'h0001);
        end
        chk("ldi_c9_data", resp_data3, 16'h00A5);
        tick();
        chk("ldi_c10_ready", 16'(req_ready3), 16'h0001);
        chk("ldi_c10_en", 16'(Data_en3), 16'h0000);
        chk("ldi_c10_busy", 16'(busy3), 16'h0000);
        req_valid3 = 1'b0;
        tick();
        chk("ldi_c11_en", 16'(Data_en3), 16'h0000);
        chk("ldi_c11_ready", 16'(req_ready3), 16'h0001);

        // Reset during WAIT1 of a STORE_IND: no write, no response.
        req_op = 2'b11; req_addr = 16'h3040; req_wdata = 16'h7777; req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        chk("abt_c1_en", 16'(Data_en3), 16'h0001);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abt_rst_ready", 16'(req_ready3), 16'h0001);
        chk("abt_rst_busy", 16'(busy3), 16'h0000);
        chk("abt_rst_addr", Data_addr3, 16'h0000);
        chk("abt_rst_rdata", resp_data3, 16'h0000);
        chk("abt_rst_rd", 16'(Data_rd3), 16'h0001);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk($sformatf("abt_p%0d_en", c), 16'(Data_en3), 16'h0000);
            chk($sformatf("abt_p%0d_rv", c), 16'(resp_valid3), 16'h0000);
            chk($sformatf("abt_p%0d_ready", c), 16'(req_ready3), 16'h0001);
        end
        chk("abt_wr_cnt", 16'(wr_cnt3), 16'h0000);

`ifdef LC3_MEM_ACCESS_PROT_EN
        // Protected STORE at 0xFE00 is suppressed but still responds with an error.
        req_op = 2'b10; req_addr = 16'hFE00; req_wdata = 16'h1111; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("prot_c1_en", 16'(Data_en1), 16'h0000);
        chk("prot_c1_ready", 16'(req_ready1), 16'h0000);
        tick();
        chk("prot_c2_rv", 16'(resp_valid1), 16'h0001);
        chk("prot_c2_err", 16'(resp_err1), 16'h0001);
        chk("prot_wr_cnt", 16'(wr_cnt1), 16'h0002);
        tick();
        chk("prot_c3_err", 16'(resp_err1), 16'h0000);
        // STORE at 0xFDFF sits just below the window and is issued.
        req_op = 2'b10; req_addr = 16'hFDFF; req_wdata = 16'h2222; req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        chk("allow_c1_en", 16'(Data_en1), 16'h0001);
        chk("allow_c1_addr", Data_addr1, 16'hFDFF);
        tick();
        chk("allow_c2_rv", 16'(resp_valid1), 16'h0001);
        chk("allow_c2_err", 16'(resp_err1), 16'h0000);
        chk("allow_wr_cnt", 16'(wr_cnt1), 16'h0003);
        chk("allow_wr_addr", wr_addr1, 16'hFDFF);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lc3_mem_access_seq.md
Name: lc3_mem_access_seq

Overview:
Memory-access sequencer for the LC3 MemAccess stage, directly upstream of the data memory port.
- Takes one load/store request from the controller/execute side and drives the data-memory bus: Data_addr, Data_din, Data_rd, Data_en.
- Sequences single accesses (LD/LDR, ST/STR) and two-access indirect ops (LDI, STI) over a fixed-latency read path.
- Returns load data to writeback with a one-cycle valid pulse.

Parameters:
- RD_LATENCY, 1: cycles from the Data_en read cycle until Data_dout is valid. Legal range 1..7.
- AW, 16: address and data width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  sequencer can accept a request; high only in IDLE.
- req_op  in  2  operation: 00 LOAD, 01 LOAD_IND (LDI), 10 STORE, 11 STORE_IND (STI).
- req_addr  in  AW  effective address (pointer address for IND ops).
- req_wdata  in  AW  store data.
- Data_addr  out  AW  memory address.
- Data_din  out  AW  memory write data.
- Data_rd  out  1  1 = read, 0 = write; qualified by Data_en.
- Data_en  out  1  one-cycle access strobe.
- Data_dout  in  AW  memory read data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  AW  load result; for stores, holds its previous value.
- busy  out  1  equals ~req_ready.

Behaviour:
- Reset (synchronous, active-high), all outputs:
  - state = IDLE, req_ready = 1, busy = 0.
  - Data_addr = 0, Data_din = 0, Data_rd = 1, Data_en = 0.
  - resp_valid = 0, resp_data = 0.
- Accept: a request is accepted at the edge where req_valid && req_ready. op, addr and wdata are latched. req_valid while busy is ignored; the requester holds it.
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, RESP.
- ISSUE1 (1 cycle):
  - Data_en = 1, Data_addr = latched addr.
  - Data_rd = 0 with Data_din = wdata for STORE; Data_rd = 1 otherwise.
  - STORE goes to RESP; all other ops go to WAIT1.
- WAIT1:
  - A counter runs RD_LATENCY cycles.
  - Data_dout is sampled at the end of the RD_LATENCY-th cycle after ISSUE1.
  - LOAD: sample goes to resp_data, next state RESP.
  - IND ops: sample goes to the pointer register, next state ISSUE2.
- ISSUE2 (1 cycle):
  - Data_en = 1, Data_addr = pointer.
  - LOAD_IND: Data_rd = 1, next state WAIT2.
  - STORE_IND: Data_rd = 0, Data_din = wdata, next state RESP.
- WAIT2: same counting as WAIT1; sample goes to resp_data, next state RESP.
- RESP (1 cycle): resp_valid = 1, then IDLE. req_ready returns high the next cycle; no back-to-back accept in the RESP cycle.
- Outside strobe cycles:
  - Data_en = 0.
  - Data_addr and Data_din hold their last driven values.
  - Data_rd returns to 1.
- Latency, cycles from accept edge to the resp_valid cycle, with L = RD_LATENCY:
  - STORE: 2
  - LOAD: L + 2
  - STORE_IND: L + 3
  - LOAD_IND: 2L + 3
- Exactly one Data_en per access; never two consecutive Data_en cycles.
- Reset asserted mid-operation: at that edge, state goes to IDLE and all outputs take their reset values. No write strobe may follow. The aborted request produces no resp_valid.
- Address wrap: 16-bit addresses; 0xFFFF is a legal address and the pointer is not incremented.
- Pointer value 0x0000 is legal and is not special-cased.

Optional Feature:
Macro: LC3_MEM_ACCESS_PROT_EN.
- Defined:
  - Adds parameter PROT_BASE, default 16'hFE00.
  - Adds output resp_err (1 bit, reset 0).
  - Any write (STORE, or the second access of STORE_IND) whose address is >= PROT_BASE is suppressed: Data_en stays 0 in that cycle.
  - Sequencing and latency are unchanged. resp_valid still pulses, with resp_err = 1 in the same cycle.
  - resp_err = 0 for all reads and for allowed writes.
- Undefined: no resp_err port, no PROT_BASE parameter; all writes are issued.

Test Plan:
1. Reset, idle: reset high 2 cycles then low -> req_ready = 1, Data_en = 0, Data_rd = 1, resp_valid = 0, resp_data = 0.
2. LOAD, RD_LATENCY = 1: op 00, addr 0x3010, memory holds 0xBEEF -> Data_en read at 0x3010 in cycle 1; resp_valid with resp_data = 0xBEEF in cycle 3.
3. STORE_IND: op 11, addr 0x3020, mem[0x3020] = 0x4000, wdata 0x1234 -> read 0x3020 in cycle 1; write 0x4000/0x1234 in cycle 3; resp_valid in cycle 4; mem[0x4000] = 0x1234.
4. LOAD_IND, RD_LATENCY = 3: mem[0x3000] = 0xFFFF, mem[0xFFFF] = 0x00A5 -> resp_data = 0x00A5 with resp_valid in cycle 9; req_valid held during busy is not re-accepted.
5. Reset mid-op: reset asserted while in WAIT1 of a STORE_IND -> no write strobe occurs, no resp_valid; req_ready = 1 the cycle after reset deasserts.
6. Protection, macro defined: STORE to 0xFE00 -> Data_en stays 0, resp_valid = 1 with resp_err = 1 in cycle 2. STORE to 0xFDFF -> write issued, resp_err = 0.
